cfsr_n: RTL and testbench
=========================

# cfsr_n

Parametrised circular feedback shift register. It is the next generation of the fixed 4-bit CFSR. It generalises width and seed, and adds run-time selection of ring, Johnson or LFSR feedback, shift direction, parallel load, a wrap pulse and lock-up detection. It is used as a sequence/phase generator and pseudo-random source in the `clk` domain of the project designs.

## Interface
Parameters:
- `WIDTH`, 4 — register width; must be ≥ 2.
- `SEED`, `{{WIDTH-1{1'b0}},1'b1}` — reset value, and the reference value for `wrap`.
- `TAPS`, `4'b1001` (sized `WIDTH`) — LFSR feedback mask; bit i set means `cfsr[i]` enters the XOR.

Ports:
- `clk` in 1 — single clock; all state updates on its rising edge.
- `rst` in 1 — synchronous, active-high reset.
- `en` in 1 — advance the sequence this cycle.
- `dir` in 1 — 0: shift toward MSB; 1: shift toward LSB. Ignored in LFSR mode.
- `mode` in 2 — 00 ring, 01 Johnson, 10 LFSR, 11 hold.
- `load` in 1 — parallel-load request.
- `load_val` in `WIDTH` — value captured on load.
- `cfsr` out `WIDTH` — register state.
- `wrap` out 1 — registered one-cycle pulse: the sequence returned to `SEED`.
- `lockup` out 1 — combinational lock-up flag.

## Operation
- Priority on each edge: `rst` > `load` > advance (`en`=1 and `mode`≠11) > hold.
- Reset: `cfsr`=`SEED`, `wrap`=0.
- Load: `cfsr`=`load_val` (any value, including 0), regardless of `en` and `mode`. `wrap`=0.
- Advance when `dir`=0 (W=`WIDTH`):
  - ring: `{cfsr[W-2:0], cfsr[W-1]}`
  - Johnson: `{cfsr[W-2:0], ~cfsr[W-1]}`
- Advance when `dir`=1:
  - ring: `{cfsr[0], cfsr[W-1:1]}`
  - Johnson: `{~cfsr[0], cfsr[W-1:1]}`
- LFSR advance: `fb = ^(cfsr & TAPS)`; next state is `{cfsr[W-2:0], fb}`. `dir` is ignored.
- Hold (`mode`=11 or `en`=0): `cfsr` unchanged; `wrap`=0.
- A `mode` or `dir` change alters no state. It takes effect on the next advance.
- `wrap`: 1 in the cycle after an advance whose result equals `SEED`; otherwise 0. Recovery transitions and loads never assert `wrap`.
- `lockup` = (`cfsr`==0) and (`mode`==00 or `mode`==10). Johnson mode and hold never flag lock-up.

## Timing
- Advance and load latency: 1 cycle, from the sampling edge to the new `cfsr`.
- `wrap` is aligned with the `cfsr`==`SEED` value it reports.
- `lockup` has 0 latency, since it is combinational from `cfsr` and `mode`.
- Reset asserted mid-sequence: `cfsr`=`SEED` and `wrap`=0 on that edge, overriding any concurrent `load` or `en`.
- `load` and `en` on the same cycle: load wins; no advance occurs.
- Johnson period is 2·W. Ring period is W for a one-hot state. LFSR period depends on `TAPS`; it is 2^W−1 for a primitive mask.

## Configuration
- `CFSR_LOCKUP_RECOVER_EN` defined:
  - An advance from a lock-up state (`lockup`=1) loads `SEED` instead of shifting.
  - `wrap` stays 0 on that transition.
- Macro not defined:
  - A ring or LFSR advance from 0 stays at 0.
  - `lockup` remains 1 until `load` or `rst`.
- The macro has no effect on Johnson mode or hold.

## Test plan
All scenarios use WIDTH=4, SEED=0001, TAPS=1001, and a 10 ns `clk`.
- Reset: `rst`=1 for 15 ns → `cfsr`=0001, `wrap`=0. Then release with `en`=1, `mode`=00, `dir`=0 → 0010, 0100, 1000, 0001, with `wrap`=1 only alongside the final 0001. Then `dir`=1 → 1000, 0100.
- Johnson: load 0000, then `mode`=01, `dir`=0, `en`=1 → 0001, 0011, 0111, 1111, 1110, 1100, 1000, 0000, repeating with period 8. `lockup` stays 0 throughout.
- LFSR: from reset, `mode`=10, `en`=1 → 0011, 0111, 1111, 1110, 1101 …; `wrap` pulses on every 15th advance (0001). Toggling `dir` does not change the sequence.
- Lock-up: load 0000 with `mode`=00 → `lockup`=1 immediately.
  - With macro: next advance → `cfsr`=0001, `wrap`=0, `lockup`=0.
  - Without macro: `cfsr` stays 0000 and `lockup` stays 1.
- Priority: `load`=1 with `load_val`=1010 and `en`=1 → `cfsr`=1010, no shift. `rst`=1 together with `load` → `cfsr`=0001.
- Hold: `mode`=11 with `en`=1 for 5 cycles → `cfsr` unchanged, `wrap`=0. `en`=0 in ring mode → `cfsr` unchanged.

Source files
------------

// File: rtl/cfsr_n.sv
// rtl/cfsr_n.sv - parametrised circular feedback shift register (ring/Johnson/LFSR)
// Optional feature macro: CFSR_LOCKUP_RECOVER_EN (advance from all-zero ring/LFSR state reloads SEED)
module cfsr_n #(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] SEED  = {{(WIDTH-1){1'b0}}, 1'b1},
  parameter logic [WIDTH-1:0] TAPS  = WIDTH'(4'b1001)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic [1:0]       mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] cfsr,
  output logic             wrap,
  output logic             lockup
);

  localparam logic [1:0] MODE_RING    = 2'b00;
  localparam logic [1:0] MODE_JOHNSON = 2'b01;
  localparam logic [1:0] MODE_LFSR    = 2'b10;
  localparam logic [1:0] MODE_HOLD    = 2'b11;

  logic [WIDTH-1:0] shifted;
  logic             fb;
  logic             advance;
  logic             recover;

  assign fb      = ^(cfsr & TAPS);
  assign advance = en && (mode != MODE_HOLD);
  assign lockup  = (cfsr == '0) && ((mode == MODE_RING) || (mode == MODE_LFSR));

`ifdef CFSR_LOCKUP_RECOVER_EN
  assign recover = lockup;
`else
  assign recover = 1'b0;
`endif

  always_comb begin
    shifted = cfsr;
    case (mode)
      MODE_RING:    shifted = dir ? {cfsr[0], cfsr[WIDTH-1:1]}
                                  : {cfsr[WIDTH-2:0], cfsr[WIDTH-1]};
      MODE_JOHNSON: shifted = dir ? {~cfsr[0], cfsr[WIDTH-1:1]}
                                  : {cfsr[WIDTH-2:0], ~cfsr[WIDTH-1]};
      // LFSR always shifts toward the MSB; dir has no meaning here
      MODE_LFSR:    shifted = {cfsr[WIDTH-2:0], fb};
      default:      shifted = cfsr;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfsr <= SEED;
      wrap <= 1'b0;
    end else if (load) begin
      cfsr <= load_val;
      wrap <= 1'b0;
    end else if (advance) begin
      if (recover) begin
        // recovery is not a real return to SEED, so it never pulses wrap
        cfsr <= SEED;
        wrap <= 1'b0;
      end else begin
        cfsr <= shifted;
        wrap <= (shifted == SEED);
      end
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule

// File: tb/tb_cfsr_n.sv
// tb/tb_cfsr_n.sv - scoreboard bench for cfsr_n against a behavioural sequence model
// Honours CFSR_LOCKUP_RECOVER_EN in the reference model when defined.
module tb_cfsr_n;

  localparam int         W    = 4;
  localparam logic [3:0] SEED = 4'b0001;
  localparam logic [3:0] TAPS = 4'b1001;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b0;
  logic       dir = 1'b0;
  logic [1:0] mode = 2'b00;
  logic       load = 1'b0;
  logic [3:0] load_val = 4'b0000;
  logic [3:0] cfsr;
  logic       wrap;
  logic       lockup;

  typedef struct {
    logic [3:0] c;
    logic       w;
    logic       l;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   m_state = 1;

  cfsr_n #(.WIDTH(W), .SEED(SEED), .TAPS(TAPS)) dut (
    .clk(clk), .rst(rst), .en(en), .dir(dir), .mode(mode),
    .load(load), .load_val(load_val),
    .cfsr(cfsr), .wrap(wrap), .lockup(lockup)
  );

  always #5 clk = ~clk;

  // Reference: each mode described as arithmetic on an integer state
  function automatic int model_next(input int v, input int m, input logic d);
    int r;
    r = v;
    case (m)
      0: r = d ? ((v >> 1) | ((v & 1) << 3)) : (((v << 1) & 15) | (v >> 3));
      1: r = d ? ((v >> 1) | (((v & 1) ^ 1) << 3)) : (((v << 1) & 15) | (((v >> 3) & 1) ^ 1));
      2: r = ((v << 1) & 15) | ($countones(v & int'(TAPS)) & 1);
      default: r = v;
    endcase
    return r;
  endfunction

  task automatic step(input logic r, input logic ld, input logic [3:0] lv,
                      input logic e, input logic d, input logic [1:0] m);
    exp_t it;
    int   nxt;
    logic w;
    @(negedge clk);
    rst = r; load = ld; load_val = lv; en = e; dir = d; mode = m;
    w = 1'b0;
    if (r) nxt = int'(SEED);
    else if (ld) nxt = int'(lv);
    else if (e && m != 2'b11) begin
      if (m_state == 0 && (m == 2'b00 || m == 2'b10)) begin
`ifdef CFSR_LOCKUP_RECOVER_EN
        nxt = int'(SEED);
`else
        nxt = 0;
`endif
      end else begin
        nxt = model_next(m_state, int'(m), d);
        w = (nxt == int'(SEED));
      end
    end else nxt = m_state;
    m_state = nxt;
    it.c = 4'(nxt);
    it.w = w;
    it.l = (nxt == 0) && (m == 2'b00 || m == 2'b10);
    exp_q.push_back(it);
  endtask

  // Monitor: every cycle the DUT presents state; compare against the oldest expectation
  always @(posedge clk) begin
    exp_t it;
    #1;
    if (exp_q.size() > 0) begin
      it = exp_q.pop_front();
      n_checks = n_checks + 3;
      if (cfsr !== it.c) begin
        n_fail = n_fail + 1;
        $display("FAIL cfsr @%0t: got %b expected %b", $time, cfsr, it.c);
      end
      if (wrap !== it.w) begin
        n_fail = n_fail + 1;
        $display("FAIL wrap @%0t: got %b expected %b (cfsr %b)", $time, wrap, it.w, cfsr);
      end
      if (lockup !== it.l) begin
        n_fail = n_fail + 1;
        $display("FAIL lockup @%0t: got %b expected %b (cfsr %b mode %b)", $time, lockup, it.l, cfsr, mode);
      end
    end
  end

  initial begin
    // reset and ring
    step(1, 0, 4'h0, 0, 0, 2'b00);
    for (int i = 0; i < 4; i++) step(0, 0, 4'h0, 1, 0, 2'b00);
    for (int i = 0; i < 2; i++) step(0, 0, 4'h0, 1, 1, 2'b00);
    // Johnson from zero, both directions
    step(0, 1, 4'h0, 1, 0, 2'b01);
    for (int i = 0; i < 16; i++) step(0, 0, 4'h0, 1, 0, 2'b01);
    for (int i = 0; i < 8; i++) step(0, 0, 4'h0, 1, 1, 2'b01);
    // LFSR full period twice, dir toggled on the second pass
    step(1, 0, 4'h0, 0, 0, 2'b10);
    for (int i = 0; i < 15; i++) step(0, 0, 4'h0, 1, 0, 2'b10);
    for (int i = 0; i < 15; i++) step(0, 0, 4'h0, 1, i[0], 2'b10);
    // lock-up in ring and LFSR, plus Johnson escaping zero
    step(0, 1, 4'h0, 0, 0, 2'b00);
    for (int i = 0; i < 2; i++) step(0, 0, 4'h0, 1, 0, 2'b00);
    step(0, 1, 4'h0, 0, 0, 2'b10);
    for (int i = 0; i < 2; i++) step(0, 0, 4'h0, 1, 0, 2'b10);
    step(0, 1, 4'h0, 0, 0, 2'b11);
    step(0, 0, 4'h0, 1, 1, 2'b01);
    // priority
    step(0, 1, 4'b1010, 1, 0, 2'b00);
    step(1, 1, 4'b1010, 1, 0, 2'b00);
    step(0, 1, 4'b1000, 1, 0, 2'b00);
    step(0, 0, 4'h0, 1, 0, 2'b00);
    // hold
    for (int i = 0; i < 5; i++) step(0, 0, 4'h0, 1, 0, 2'b11);
    for (int i = 0; i < 3; i++) step(0, 0, 4'h0, 0, 0, 2'b00);
    // randomized
    for (int i = 0; i < 400; i++)
      step(($urandom_range(0, 31) == 0), ($urandom_range(0, 7) == 0),
           4'($urandom_range(0, 15)), ($urandom_range(0, 3) != 0),
           1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)));
    step(0, 0, 4'h0, 0, 0, 2'b11);
    repeat (3) @(negedge clk);
    n_checks = n_checks + 1;
    if (exp_q.size() != 0) begin
      n_fail = n_fail + 1;
      $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
